data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the CPU datapath (port A) and the debug/loader engine (port B). Serialises accesses with a req/ack handshake, drives the memory's Rd/Wr/Addr/In_Data from registers so its level-sensitive write is never glitched, and returns captured read data to the winner. It sits between the requesters and the data memory instance.

---
 rtl/data_mem_arb_pkg.sv | 17 +
 rtl/data_mem_arb_pick.sv | 36 +++
 rtl/data_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

    localparam int unsigned ADDR_BUS  = 11;
    localparam int unsigned DATA_SIZE = 16;

    // Index of each requester in the one-hot grant vector
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_arb_pick.sv
// Combinational 2-way grant picker.
// DATA_MEM_ARB_RR_EN defined: ties go to the port not granted last.
// Undefined: fixed priority, port A wins ties and last_b_i is ignored.
module arb_rr_pick
    import data_mem_arb_pkg::*;
(
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       last_b_i,
    output logic [1:0] gnt_c_o
);

`ifndef DATA_MEM_ARB_RR_EN
    logic unused_last_b;
    assign unused_last_b = last_b_i;
`endif

    // One-hot grant selection
    always_comb begin
        gnt_c_o = '0;
`ifdef DATA_MEM_ARB_RR_EN
        if (req_a_i && req_b_i) begin
            if (last_b_i) gnt_c_o[PORT_A] = 1'b1;
            else          gnt_c_o[PORT_B] = 1'b1;
        end else if (req_a_i) begin
            gnt_c_o[PORT_A] = 1'b1;
        end else if (req_b_i) begin
            gnt_c_o[PORT_B] = 1'b1;
        end
`else
        if (req_a_i)      gnt_c_o[PORT_A] = 1'b1;
        else if (req_b_i) gnt_c_o[PORT_B] = 1'b1;
`endif
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory (CPU = A, loader = B).
// Optional round-robin tie-break with DATA_MEM_ARB_RR_EN; fixed A priority otherwise.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req_A,
    input  logic                 Rd_A,
    input  logic                 Wr_A,
    input  logic [ADDR_BUS-1:0]  Addr_A,
    input  logic [DATA_SIZE-1:0] Wr_Data_A,
    input  logic                 Req_B,
    input  logic                 Rd_B,
    input  logic                 Wr_B,
    input  logic [ADDR_BUS-1:0]  Addr_B,
    input  logic [DATA_SIZE-1:0] Wr_Data_B,
    output logic                 Ack_A,
    output logic                 Ack_B,
    output logic [DATA_SIZE-1:0] Rd_Data_A,
    output logic [DATA_SIZE-1:0] Rd_Data_B,
    output logic                 Mem_Rd,
    output logic                 Mem_Wr,
    output logic [ADDR_BUS-1:0]  Mem_Addr,
    output logic [DATA_SIZE-1:0] Mem_In_Data,
    input  logic [DATA_SIZE-1:0] Mem_Out_Data,
    output logic                 Busy
);

    state_e               state_q, state_d;
    logic                 win_b_q, win_b_d;
    logic                 cmd_rd_q, cmd_rd_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [ADDR_BUS-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_SIZE-1:0] mem_in_q, mem_in_d;
    logic [DATA_SIZE-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_SIZE-1:0] rd_data_b_q, rd_data_b_d;
    logic                 ack_a_q, ack_a_d;
    logic                 ack_b_q, ack_b_d;
    logic                 busy_q, busy_d;
    logic [DATA_SIZE-1:0] rd_val_c;
    logic [1:0]           gnt_c;
    logic                 any_req_c;
    logic                 last_b;

    arb_rr_pick u_pick (
        .req_a_i  (Req_A),
        .req_b_i  (Req_B),
        .last_b_i (last_b),
        .gnt_c_o  (gnt_c)
    );

    assign any_req_c = |gnt_c;

`ifdef DATA_MEM_ARB_RR_EN
    logic last_b_q, last_b_d;

    // Pointer follows every grant taken in IDLE
    always_comb begin
        last_b_d = last_b_q;
        if (state_q == ST_IDLE && any_req_c) last_b_d = gnt_c[PORT_B];
    end

    // Pointer register; reset means "B was granted last"
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) last_b_q <= 1'b1;
        else       last_b_q <= last_b_d;
    end

    assign last_b = last_b_q;
`else
    assign last_b = 1'b1;
`endif

    // Next-state: one access takes IDLE -> ACCESS -> DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req_c) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output next values: command load, read capture, Ack pulse
    always_comb begin
        win_b_d     = win_b_q;
        cmd_rd_d    = cmd_rd_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_in_d    = mem_in_q;
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        ack_a_d     = 1'b0;
        ack_b_d     = 1'b0;
        rd_val_c    = mem_rd_q ? Mem_Out_Data : '0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    win_b_d    = gnt_c[PORT_B];
                    cmd_rd_d   = gnt_c[PORT_B] ? Rd_B      : Rd_A;
                    mem_wr_d   = gnt_c[PORT_B] ? Wr_B      : Wr_A;
                    mem_addr_d = gnt_c[PORT_B] ? Addr_B    : Addr_A;
                    mem_in_d   = gnt_c[PORT_B] ? Wr_Data_B : Wr_Data_A;
                    // Write wins when both commands are set
                    mem_rd_d   = cmd_rd_d & ~mem_wr_d;
                end else begin
                    mem_addr_d = '0;
                    mem_in_d   = '0;
                end
            end
            ST_ACCESS: begin
                // Write-only keeps old read data; read, Rd+Wr and no-op update it
                if (!mem_wr_q || cmd_rd_q) begin
                    if (win_b_q) rd_data_b_d = rd_val_c;
                    else         rd_data_a_d = rd_val_c;
                end
                ack_a_d = ~win_b_q;
                ack_b_d = win_b_q;
            end
            ST_DONE: begin
                mem_addr_d = '0;
                mem_in_d   = '0;
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            win_b_q     <= 1'b0;
            cmd_rd_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_in_q    <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_b_q     <= win_b_d;
            cmd_rd_q    <= cmd_rd_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_in_q    <= mem_in_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            busy_q      <= busy_d;
        end
    end

    assign Ack_A       = ack_a_q;
    assign Ack_B       = ack_b_q;
    assign Rd_Data_A   = rd_data_a_q;
    assign Rd_Data_B   = rd_data_b_q;
    assign Mem_Rd      = mem_rd_q;
    assign Mem_Wr      = mem_wr_q;
    assign Mem_Addr    = mem_addr_q;
    assign Mem_In_Data = mem_in_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data memory.
module tb_data_mem_arbiter;

`ifdef DATA_MEM_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req_A = 1'b0, Rd_A = 1'b0, Wr_A = 1'b0;
    logic [10:0] Addr_A = '0;
    logic [15:0] Wr_Data_A = '0;
    logic        Req_B = 1'b0, Rd_B = 1'b0, Wr_B = 1'b0;
    logic [10:0] Addr_B = '0;
    logic [15:0] Wr_Data_B = '0;
    logic        Ack_A, Ack_B, Mem_Rd, Mem_Wr, Busy;
    logic [15:0] Rd_Data_A, Rd_Data_B, Mem_In_Data, Mem_Out_Data;
    logic [10:0] Mem_Addr;

    logic [15:0] tb_mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    data_mem_arbiter dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req_A        (Req_A),
        .Rd_A         (Rd_A),
        .Wr_A         (Wr_A),
        .Addr_A       (Addr_A),
        .Wr_Data_A    (Wr_Data_A),
        .Req_B        (Req_B),
        .Rd_B         (Rd_B),
        .Wr_B         (Wr_B),
        .Addr_B       (Addr_B),
        .Wr_Data_B    (Wr_Data_B),
        .Ack_A        (Ack_A),
        .Ack_B        (Ack_B),
        .Rd_Data_A    (Rd_Data_A),
        .Rd_Data_B    (Rd_Data_B),
        .Mem_Rd       (Mem_Rd),
        .Mem_Wr       (Mem_Wr),
        .Mem_Addr     (Mem_Addr),
        .Mem_In_Data  (Mem_In_Data),
        .Mem_Out_Data (Mem_Out_Data),
        .Busy         (Busy)
    );

    // Memory stand-in: combinational read, write while strobe is high at the edge
    assign Mem_Out_Data = tb_mem[Mem_Addr];
    always @(posedge Clk) if (Mem_Wr) tb_mem[Mem_Addr] <= Mem_In_Data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req_A = 1'b0; Rd_A = 1'b0; Wr_A = 1'b0;
        Req_B = 1'b0; Rd_B = 1'b0; Wr_B = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // One single-port access from a negedge; checks latency, strobes, Ack width
    task automatic do_access(input string tag, input bit on_b, input bit rd, input bit wr,
                             input logic [10:0] addr, input logic [15:0] wdata,
                             input int exp_wr, input int exp_rd);
        int lat, n_wr, n_rd;
        logic [10:0] seen_addr;
        bit seen;
        if (on_b) begin Req_B = 1'b1; Rd_B = rd; Wr_B = wr; Addr_B = addr; Wr_Data_B = wdata; end
        else      begin Req_A = 1'b1; Rd_A = rd; Wr_A = wr; Addr_A = addr; Wr_Data_A = wdata; end
        lat = 0; n_wr = 0; n_rd = 0; seen = 1'b0; seen_addr = '0;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge Clk);
            if (Mem_Wr) n_wr++;
            if (Mem_Rd) n_rd++;
            if (i == 1) seen_addr = Mem_Addr;
            if (on_b ? Ack_B : Ack_A) begin lat = i; seen = 1'b1; end
        end
        if (on_b) begin Req_B = 1'b0; Rd_B = 1'b0; Wr_B = 1'b0; end
        else      begin Req_A = 1'b0; Rd_A = 1'b0; Wr_A = 1'b0; end
        chk({tag, "_ack_cycle"}, 32'(lat), 32'd2);
        chk({tag, "_wr_cycles"}, 32'(n_wr), 32'(exp_wr));
        chk({tag, "_rd_cycles"}, 32'(n_rd), 32'(exp_rd));
        chk({tag, "_addr"}, 32'(seen_addr), 32'(addr));
        @(negedge Clk);
        chk({tag, "_ack_drop"}, 32'({Ack_A, Ack_B}), 32'd0);
        chk({tag, "_idle"}, 32'({Busy, Mem_Rd, Mem_Wr, Mem_Addr}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb, nack;
        logic [1:0] exp_ack;
        for (int i = 0; i < 2048; i++) tb_mem[i] = '0;

        // Reset state
        do_reset();
        chk("rst_acks", 32'({Ack_A, Ack_B, Busy}), 32'd0);
        chk("rst_mem", 32'({Mem_Rd, Mem_Wr, Mem_Addr}), 32'd0);
        chk("rst_memin", 32'(Mem_In_Data), 32'd0);
        chk("rst_rd_a", 32'(Rd_Data_A), 32'd0);
        chk("rst_rd_b", 32'(Rd_Data_B), 32'd0);

        // B writes, A reads back
        do_access("b_wr", 1'b1, 1'b0, 1'b1, 11'h005, 16'h1234, 1, 0);
        do_access("a_rd", 1'b0, 1'b1, 1'b0, 11'h005, 16'h0000, 0, 1);
        chk("a_rd_data", 32'(Rd_Data_A), 32'h1234);
        chk("b_rd_untouched", 32'(Rd_Data_B), 32'd0);

        // Simultaneous writes to one address: A first, B second
        do_reset();
        Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 11'h010; Wr_Data_A = 16'hAAAA;
        Req_B = 1'b1; Wr_B = 1'b1; Addr_B = 11'h010; Wr_Data_B = 16'h5555;
        ta = 0; tb = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            if (Ack_A && ta == 0) begin ta = i; Req_A = 1'b0; Wr_A = 1'b0; end
            if (Ack_B && tb == 0) begin tb = i; Req_B = 1'b0; Wr_B = 1'b0; end
        end
        chk("tie_ack_a_cycle", 32'(ta), 32'd2);
        chk("tie_ack_b_cycle", 32'(tb), 32'd5);
        do_access("tie_rd", 1'b0, 1'b1, 1'b0, 11'h010, 16'h0000, 0, 1);
        chk("tie_rd_data", 32'(Rd_Data_A), 32'h5555);

        // Write-only keeps read data; Rd+Wr writes and zeroes read data
        do_access("a_wronly", 1'b0, 1'b0, 1'b1, 11'h100, 16'h0042, 1, 0);
        chk("wronly_keeps", 32'(Rd_Data_A), 32'h5555);
        do_access("a_rdwr", 1'b0, 1'b1, 1'b1, 11'h7FF, 16'hBEEF, 1, 0);
        chk("rdwr_data_zero", 32'(Rd_Data_A), 32'd0);
        do_access("a_rd_7ff", 1'b0, 1'b1, 1'b0, 11'h7FF, 16'h0000, 0, 1);
        chk("rd_7ff_data", 32'(Rd_Data_A), 32'hBEEF);

        // Both requests held: RR alternates, fixed starves B
        do_reset();
        Req_A = 1'b1; Rd_A = 1'b1; Addr_A = 11'h005;
        Req_B = 1'b1; Rd_B = 1'b1; Addr_B = 11'h010;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            exp_ack = 2'b00;
            if (i % 3 == 2) exp_ack = (RR_BUILD && (i == 5 || i == 11)) ? 2'b01 : 2'b10;
            chk($sformatf("held_ack_%0d", i), 32'({Ack_A, Ack_B}), 32'(exp_ack));
        end
        Req_A = 1'b0; Rd_A = 1'b0; Req_B = 1'b0; Rd_B = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset during ACCESS of a B write
        do_reset();
        Req_B = 1'b1; Wr_B = 1'b1; Addr_B = 11'h020; Wr_Data_B = 16'h7777;
        @(posedge Clk);
        #2;
        chk("pre_rst_access", 32'({Busy, Mem_Wr, Mem_Addr}), 32'({1'b1, 1'b1, 11'h020}));
        Reset = 1'b1;
        #1;
        chk("async_rst_mem", 32'({Busy, Mem_Rd, Mem_Wr, Mem_Addr}), 32'd0);
        Req_B = 1'b0; Wr_B = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        nack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (Ack_A || Ack_B || Busy || Mem_Wr || Mem_Rd) nack++;
        end
        chk("rst_no_activity", 32'(nack), 32'd0);
        chk("rst_outputs", 32'({Rd_Data_A, Rd_Data_B}), 32'd0);
        do_access("rd_020", 1'b0, 1'b1, 1'b0, 11'h020, 16'h0000, 0, 1);
        chk("rd_020_data", 32'(Rd_Data_A), 32'd0);

        // No-op slot clears read data and never strobes memory
        do_access("a_rd_7ff_2", 1'b0, 1'b1, 1'b0, 11'h7FF, 16'h0000, 0, 1);
        chk("rd_7ff_2_data", 32'(Rd_Data_A), 32'hBEEF);
        do_access("noop", 1'b0, 1'b0, 1'b0, 11'h033, 16'h9999, 0, 0);
        chk("noop_data", 32'(Rd_Data_A), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
